// File: rtl/uart_state_cmd_rx.sv
// uart_state_cmd_rx: UART receiver and command parser for the VNA switch sequencer.
// Receives ASCII switch commands, decodes them into a 2-bit switch state and
// raises a one-cycle arrival strobe when a CR or LF terminator follows a command.
// Optional build macro: UART_RX_PARITY_EN selects 8E1 framing (default is 8N1).
module uart_state_cmd_rx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       uart_rx,
    output logic [1:0] new_state,
    output logic       new_state_arrived,
    output logic       cmd_err,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rxState_e;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rxState_e;
`endif

    logic             rxMeta_q, rxSync_q, rxPrev_q;
    rxState_e         state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bitIdx_q, bitIdx_d;
    logic [7:0]       rxByte_q, rxByte_d;
    logic             byteValid_q, byteValid_d;
    logic             frameErr_q, frameErr_d;
    logic             stopGood;
    logic [1:0]       pending_q, pending_d;
    logic             pendV_q, pendV_d;
    logic [1:0]       newState_q, newState_d;
    logic             arrived_q, arrived_d;
    logic             cmdErr_q, cmdErr_d;
`ifdef UART_RX_PARITY_EN
    logic             parErr_q, parErr_d;
`endif

    // Two-flop synchroniser for the asynchronous line, plus a delayed copy for edge detection.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
            rxPrev_q <= 1'b1;
        end else begin
            rxMeta_q <= uart_rx;
            rxSync_q <= rxMeta_q;
            rxPrev_q <= rxSync_q;
        end
    end

`ifdef UART_RX_PARITY_EN
    assign stopGood = rxSync_q && !parErr_q;
`else
    assign stopGood = rxSync_q;
`endif

    // Receiver next-state logic: mid-bit sampling of start, data, optional parity and stop bits.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        bitIdx_d    = bitIdx_q;
        rxByte_d    = rxByte_q;
        byteValid_d = 1'b0;
        frameErr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        parErr_d    = parErr_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rxPrev_q && !rxSync_q) begin
                    state_d  = START;
                    bitIdx_d = 3'd0;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rxSync_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d    = '0;
                    rxByte_d = {rxSync_q, rxByte_q[7:1]};
                    bitIdx_d = bitIdx_q + 3'd1;
                    if (bitIdx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d    = '0;
                    parErr_d = (^rxByte_q) ^ rxSync_q;
                    state_d  = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (stopGood) begin
                        byteValid_d = 1'b1;
                    end else begin
                        frameErr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Command parser: a command byte arms the pending state, a terminator publishes it.
    always_comb begin
        pending_d  = pending_q;
        pendV_d    = pendV_q;
        newState_d = newState_q;
        arrived_d  = 1'b0;
        cmdErr_d   = 1'b0;
        if (byteValid_q) begin
            case (rxByte_q)
                8'h30: begin pending_d = 2'd0; pendV_d = 1'b1; end
                8'h31: begin pending_d = 2'd1; pendV_d = 1'b1; end
                8'h32: begin pending_d = 2'd2; pendV_d = 1'b1; end
                8'h52,
                8'h72: begin pending_d = 2'd3; pendV_d = 1'b1; end
                8'h0D,
                8'h0A: begin
                    if (pendV_q) begin
                        newState_d = pending_q;
                        arrived_d  = 1'b1;
                        pendV_d    = 1'b0;
                    end
                end
                default: begin
                    cmdErr_d = 1'b1;
                    pendV_d  = 1'b0;
                end
            endcase
        end
    end

    // State register for receiver and parser; reset drops any partial frame and pending command.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bitIdx_q    <= 3'd0;
            rxByte_q    <= 8'h00;
            byteValid_q <= 1'b0;
            frameErr_q  <= 1'b0;
            pending_q   <= 2'd0;
            pendV_q     <= 1'b0;
            newState_q  <= 2'd0;
            arrived_q   <= 1'b0;
            cmdErr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parErr_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bitIdx_q    <= bitIdx_d;
            rxByte_q    <= rxByte_d;
            byteValid_q <= byteValid_d;
            frameErr_q  <= frameErr_d;
            pending_q   <= pending_d;
            pendV_q     <= pendV_d;
            newState_q  <= newState_d;
            arrived_q   <= arrived_d;
            cmdErr_q    <= cmdErr_d;
`ifdef UART_RX_PARITY_EN
            parErr_q    <= parErr_d;
`endif
        end
    end

    assign new_state         = newState_q;
    assign new_state_arrived = arrived_q;
    assign cmd_err           = cmdErr_q;
    assign frame_err         = frameErr_q;
    assign rx_busy           = (state_q != IDLE);

endmodule

// File: tb/tb_uart_state_cmd_rx.sv
// tb_uart_state_cmd_rx: directed bench for uart_state_cmd_rx at 10 clocks per bit.
// Honours UART_RX_PARITY_EN the same way as the design (8E1 frames when defined).
module tb_uart_state_cmd_rx;

    localparam int CPB = 10;
`ifdef UART_RX_PARITY_EN
    localparam int EXTRA_BITS = 1;
`else
    localparam int EXTRA_BITS = 0;
`endif
    // Line falls before edge C+1; detection at C+3; start sample at C+8; each later bit
    // sample CPB later; stop sample at C+98 (+CPB with parity); strobe visible one cycle
    // after byte_valid, i.e. cycle count C+99 (+CPB with parity).
    localparam int ARRIVE_LAT = 99 + CPB * EXTRA_BITS;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       uart_rx = 1'b1;
    logic [1:0] new_state;
    logic       new_state_arrived;
    logic       cmd_err;
    logic       frame_err;
    logic       rx_busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int   arrivedCnt = 0, cmdErrCnt = 0, frameErrCnt = 0;
    int   busyRise = 0, busyCycles = 0, badChange = 0, lastArrCyc = -1;
    logic [1:0] lastState = 2'd0;
    logic [1:0] prevState = 2'd0;
    logic       busyPrev = 1'b0;

    int arrBase, cmdBase, frmBase, riseBase, busyBase;
    int startCyc;

    uart_state_cmd_rx #(.CLK_FREQ(1_000_000), .BAUD(100_000)) dut (
        .Clk               (Clk),
        .Rst_n             (Rst_n),
        .uart_rx           (uart_rx),
        .new_state         (new_state),
        .new_state_arrived (new_state_arrived),
        .cmd_err           (cmd_err),
        .frame_err         (frame_err),
        .rx_busy           (rx_busy)
    );

    // Free-running clock and edge counter.
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // Strobe monitor sampled on the falling edge, away from the active edge.
    always @(negedge Clk) begin
        if (new_state_arrived) begin
            arrivedCnt++;
            lastState  = new_state;
            lastArrCyc = cyc;
        end
        if (cmd_err) cmdErrCnt++;
        if (frame_err) frameErrCnt++;
        if (rx_busy && !busyPrev) busyRise++;
        if (rx_busy) busyCycles++;
        if (Rst_n && (new_state !== prevState) && !new_state_arrived) badChange++;
        busyPrev  = rx_busy;
        prevState = new_state;
    end

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drive one serial frame; stopBit low forces a framing error, parFlip corrupts parity.
    task automatic applyStimulus(input logic [7:0] b, input logic stopBit, input logic parFlip);
        @(negedge Clk);
        startCyc = cyc;
        uart_rx = 1'b0;
        repeat (CPB) @(negedge Clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge Clk);
        end
`ifdef UART_RX_PARITY_EN
        uart_rx = (^b) ^ parFlip;
        repeat (CPB) @(negedge Clk);
`else
        if (parFlip) uart_rx = 1'b1;
`endif
        uart_rx = stopBit;
        repeat (CPB) @(negedge Clk);
        uart_rx = 1'b1;
    endtask

    task automatic snapshot();
        arrBase  = arrivedCnt;
        cmdBase  = cmdErrCnt;
        frmBase  = frameErrCnt;
        riseBase = busyRise;
        busyBase = busyCycles;
    endtask

    task automatic settle();
        repeat (6) @(negedge Clk);
    endtask

    initial begin
        int lfStart;
        $display("[TB] start, CLKS_PER_BIT=%0d", CPB);

        // Reset state
        repeat (3) @(negedge Clk);
        checkOutput("rst_new_state", 32'(new_state), 32'd0);
        checkOutput("rst_arrived", 32'(new_state_arrived), 32'd0);
        checkOutput("rst_cmd_err", 32'(cmd_err), 32'd0);
        checkOutput("rst_frame_err", 32'(frame_err), 32'd0);
        checkOutput("rst_rx_busy", 32'(rx_busy), 32'd0);
        @(posedge Clk); #1 Rst_n = 1'b1;
        repeat (5) @(negedge Clk);

        // '1' LF -> state 1 with exact strobe latency
        snapshot();
        applyStimulus(8'h31, 1'b1, 1'b0);
        applyStimulus(8'h0A, 1'b1, 1'b0);
        lfStart = startCyc;
        settle();
        checkOutput("s1_arrived_cnt", 32'(arrivedCnt - arrBase), 32'd1);
        checkOutput("s1_state", 32'(lastState), 32'd1);
        checkOutput("s1_latency", 32'(lastArrCyc), 32'(lfStart + ARRIVE_LAT));
        checkOutput("s1_cmd_err", 32'(cmdErrCnt - cmdBase), 32'd0);
        checkOutput("s1_frame_err", 32'(frameErrCnt - frmBase), 32'd0);
        checkOutput("s1_busy_frames", 32'(busyRise - riseBase), 32'd2);

        // 'R' CR LF -> exactly one strobe, state 3
        snapshot();
        applyStimulus(8'h52, 1'b1, 1'b0);
        applyStimulus(8'h0D, 1'b1, 1'b0);
        applyStimulus(8'h0A, 1'b1, 1'b0);
        settle();
        checkOutput("crlf_arrived_cnt", 32'(arrivedCnt - arrBase), 32'd1);
        checkOutput("crlf_state", 32'(new_state), 32'd3);

        // '0' '2' LF -> last command wins
        snapshot();
        applyStimulus(8'h30, 1'b1, 1'b0);
        applyStimulus(8'h32, 1'b1, 1'b0);
        applyStimulus(8'h0A, 1'b1, 1'b0);
        settle();
        checkOutput("lastwin_arrived_cnt", 32'(arrivedCnt - arrBase), 32'd1);
        checkOutput("lastwin_state", 32'(new_state), 32'd2);

        // 'x' LF -> cmd_err, no strobe, state held
        snapshot();
        applyStimulus(8'h78, 1'b1, 1'b0);
        applyStimulus(8'h0A, 1'b1, 1'b0);
        settle();
        checkOutput("bad_cmd_err", 32'(cmdErrCnt - cmdBase), 32'd1);
        checkOutput("bad_arrived_cnt", 32'(arrivedCnt - arrBase), 32'd0);
        checkOutput("bad_state_hold", 32'(new_state), 32'd2);

        // 3-cycle glitch -> short busy pulse, no strobes, then '0' LF
        snapshot();
        @(negedge Clk);
        uart_rx = 1'b0;
        repeat (3) @(negedge Clk);
        uart_rx = 1'b1;
        repeat (20) @(negedge Clk);
        checkOutput("glitch_busy_rise", 32'(busyRise - riseBase), 32'd1);
        checkOutput("glitch_busy_cycles", 32'(busyCycles - busyBase), 32'd5);
        checkOutput("glitch_busy_now", 32'(rx_busy), 32'd0);
        checkOutput("glitch_strobes", 32'((arrivedCnt - arrBase) + (cmdErrCnt - cmdBase) + (frameErrCnt - frmBase)), 32'd0);
        snapshot();
        applyStimulus(8'h30, 1'b1, 1'b0);
        applyStimulus(8'h0A, 1'b1, 1'b0);
        settle();
        checkOutput("glitch_after_cnt", 32'(arrivedCnt - arrBase), 32'd1);
        checkOutput("glitch_after_state", 32'(new_state), 32'd0);

        // 0x31 with low stop bit, LF -> frame_err, no strobe
        snapshot();
        applyStimulus(8'h31, 1'b0, 1'b0);
        applyStimulus(8'h0A, 1'b1, 1'b0);
        settle();
        checkOutput("stop_frame_err", 32'(frameErrCnt - frmBase), 32'd1);
        checkOutput("stop_arrived_cnt", 32'(arrivedCnt - arrBase), 32'd0);
        checkOutput("stop_cmd_err", 32'(cmdErrCnt - cmdBase), 32'd0);

        // Pending '2', reset during bit 4 of another '2', then LF alone, then '1' LF
        snapshot();
        applyStimulus(8'h32, 1'b1, 1'b0);
        @(negedge Clk);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge Clk);
        for (int i = 0; i < 4; i++) begin
            uart_rx = (i == 1) ? 1'b1 : 1'b0;
            repeat (CPB) @(negedge Clk);
        end
        uart_rx = 1'b1;
        repeat (5) @(negedge Clk);
        @(posedge Clk); #1 Rst_n = 1'b0;
        @(negedge Clk);
        checkOutput("rstmid_busy", 32'(rx_busy), 32'd0);
        checkOutput("rstmid_state", 32'(new_state), 32'd0);
        repeat (2) @(negedge Clk);
        @(posedge Clk); #1 Rst_n = 1'b1;
        repeat (20) @(negedge Clk);
        applyStimulus(8'h0A, 1'b1, 1'b0);
        settle();
        checkOutput("rstmid_pend_lost", 32'((arrivedCnt - arrBase) + (cmdErrCnt - cmdBase) + (frameErrCnt - frmBase)), 32'd0);
        applyStimulus(8'h31, 1'b1, 1'b0);
        applyStimulus(8'h0A, 1'b1, 1'b0);
        settle();
        checkOutput("rstmid_arrived_cnt", 32'(arrivedCnt - arrBase), 32'd1);
        checkOutput("rstmid_new_state", 32'(new_state), 32'd1);

`ifdef UART_RX_PARITY_EN
        // Wrong parity -> frame_err, nothing decoded; parity + stop error -> single pulse
        snapshot();
        applyStimulus(8'h32, 1'b1, 1'b1);
        applyStimulus(8'h0A, 1'b1, 1'b0);
        settle();
        checkOutput("par_frame_err", 32'(frameErrCnt - frmBase), 32'd1);
        checkOutput("par_arrived_cnt", 32'(arrivedCnt - arrBase), 32'd0);
        checkOutput("par_state_hold", 32'(new_state), 32'd1);
        snapshot();
        applyStimulus(8'h30, 1'b0, 1'b1);
        settle();
        checkOutput("par_stop_single", 32'(frameErrCnt - frmBase), 32'd1);
`endif

        checkOutput("state_only_on_strobe", 32'(badChange), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
